// File: rtl/bus_share_arbiter.sv
// Round-robin arbiter for a shared tri-state word bus: registered one-hot
// grant (drives buffer enables), encoded owner index, one-cycle turnaround
// gap between owners, and a per-tenure hold limit that lock can override.
module bus_share_arbiter #(
  parameter int unsigned requester_num = 4,
  parameter int unsigned max_hold      = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [requester_num-1:0]         req,
  input  logic [requester_num-1:0]         lock,
  output logic [requester_num-1:0]         grant,
  output logic [$clog2(requester_num)-1:0] grant_idx,
  output logic                             busy,
  output logic                             preempt
);

  localparam int unsigned IDX_W = $clog2(requester_num);
  localparam int unsigned CNT_W = $clog2(max_hold + 1);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t                   state, state_n;
  logic [IDX_W-1:0]         ptr, ptr_n, idx_n, pick, ptr_after;
  logic                     pick_vld;
  logic [CNT_W-1:0]         hold_cnt, hold_n;
  logic [requester_num-1:0] grant_n, others;
  logic                     preempt_n;

  assign busy      = (state != IDLE);
  assign others    = req & ~grant;
  assign ptr_after = (grant_idx == IDX_W'(requester_num - 1)) ? '0 : grant_idx + 1'b1;

  // First requester at or above the pointer, wrapping at requester_num rather than 2^IDX_W.
  always_comb begin
    int unsigned cand;
    cand     = 0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int unsigned i = 0; i < requester_num; i++) begin
      cand = 32'(ptr) + i;
      if (cand >= requester_num) cand = cand - requester_num;
      if (!pick_vld && req[IDX_W'(cand)]) begin
        pick     = IDX_W'(cand);
        pick_vld = 1'b1;
      end
    end
  end

  // Next-state, grant, pointer and hold-counter decisions.
  always_comb begin
    state_n   = state;
    grant_n   = grant;
    idx_n     = grant_idx;
    ptr_n     = ptr;
    hold_n    = hold_cnt;
    preempt_n = 1'b0;
    unique case (state)
      IDLE, TURN: begin
        if (pick_vld) begin
          grant_n       = '0;
          grant_n[pick] = 1'b1;
          idx_n         = pick;
          hold_n        = CNT_W'(1);
          state_n       = GRANT;
        end else begin
          state_n = IDLE;
        end
      end
      GRANT: begin
        if (!req[grant_idx]) begin
          grant_n = '0;
          ptr_n   = ptr_after;
          state_n = TURN;
        end else if (!lock[grant_idx] && hold_cnt == CNT_W'(max_hold) && |others) begin
          grant_n   = '0;
          ptr_n     = ptr_after;
          preempt_n = 1'b1;
          state_n   = TURN;
        end else if (hold_cnt != CNT_W'(max_hold)) begin
          hold_n = hold_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers; async reset drops the grant immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      grant     <= '0;
      grant_idx <= '0;
      ptr       <= '0;
      hold_cnt  <= '0;
      preempt   <= 1'b0;
    end else begin
      state     <= state_n;
      grant     <= grant_n;
      grant_idx <= idx_n;
      ptr       <= ptr_n;
      hold_cnt  <= hold_n;
      preempt   <= preempt_n;
    end
  end

endmodule

// File: tb/tb_bus_share_arbiter.sv
// Bench for bus_share_arbiter: directed scenarios plus randomized traffic
// against a tenure-level reference model, on a 4-requester and a
// 3-requester instance.
module tb_bus_share_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req4, lock4, grant4;
  logic [1:0] idx4;
  logic       busy4, pre4;
  logic [2:0] req3, lock3, grant3;
  logic [1:0] idx3;
  logic       busy3, pre3;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  bus_share_arbiter #(.requester_num(4), .max_hold(4)) u_dut4 (
    .clk(clk), .reset(reset), .req(req4), .lock(lock4),
    .grant(grant4), .grant_idx(idx4), .busy(busy4), .preempt(pre4)
  );

  bus_share_arbiter #(.requester_num(3), .max_hold(2)) u_dut3 (
    .clk(clk), .reset(reset), .req(req3), .lock(lock3),
    .grant(grant3), .grant_idx(idx3), .busy(busy3), .preempt(pre3)
  );

  // Reference model: who owns the bus, how long they have held it, whether
  // a turnaround gap is in progress, and where round-robin search starts.
  typedef struct {
    int owner;   // -1 when nobody holds the bus
    bit gap;
    int ptr;
    int tenure;
    bit pre;
    int last;
  } model_t;

  model_t m4, m3;

  function automatic model_t model_reset();
    model_t r;
    r.owner = -1; r.gap = 0; r.ptr = 0; r.tenure = 0; r.pre = 0; r.last = 0;
    return r;
  endfunction

  function automatic model_t model_step(model_t m, int rq, int lk, int n, int h);
    model_t r = m;
    r.pre = 0;
    if (r.owner >= 0) begin
      if (((rq >> r.owner) & 1) == 0) begin
        r.ptr = (r.owner + 1) % n; r.owner = -1; r.gap = 1;
      end else if (((lk >> r.owner) & 1) == 0 && r.tenure >= h &&
                   (rq & ~(1 << r.owner)) != 0) begin
        r.ptr = (r.owner + 1) % n; r.owner = -1; r.gap = 1; r.pre = 1;
      end else begin
        r.tenure++;
      end
    end else begin
      r.gap = 0;
      for (int k = 0; k < n; k++) begin
        int c;
        c = (r.ptr + k) % n;
        if (r.owner < 0 && ((rq >> c) & 1) != 0) begin
          r.owner = c; r.last = c; r.tenure = 1;
        end
      end
    end
    return r;
  endfunction

  function automatic int exp_grant(model_t m);
    return (m.owner >= 0) ? (1 << m.owner) : 0;
  endfunction

  function automatic int exp_idx(model_t m);
    return (m.owner >= 0) ? m.owner : m.last;
  endfunction

  // Advance both models on every clock edge, reset asynchronously with the DUTs.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m4 = model_reset();
      m3 = model_reset();
    end else begin
      m4 = model_step(m4, int'(req4), int'(lock4), 4, 4);
      m3 = model_step(m3, int'(req3), int'(lock3), 3, 2);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; req4 = '0; lock4 = '0; req3 = '0; lock3 = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; req4 = '0; lock4 = '0; req3 = '0; lock3 = '0;
    repeat (2) @(negedge clk);
    total++; if (grant4 !== 4'b0000) $display("FAIL reset_grant4 got %b exp 0000", grant4); else passed++;
    total++; if (idx4 !== 2'd0) $display("FAIL reset_idx4 got %0d exp 0", idx4); else passed++;
    total++; if (busy4 !== 1'b0 || pre4 !== 1'b0) $display("FAIL reset_busy_pre4 got %b%b exp 00", busy4, pre4); else passed++;
    total++; if (grant3 !== 3'b000 || busy3 !== 1'b0) $display("FAIL reset_dut3 got %b/%b exp 000/0", grant3, busy3); else passed++;
    reset = 1'b1;
  endtask

  task automatic test_sole();
    do_reset();
    req4 = 4'b0001;
    @(negedge clk);
    total++; if (grant4 !== 4'b0001 || idx4 !== 2'd0) $display("FAIL sole_latency got %b/%0d exp 0001/0", grant4, idx4); else passed++;
    total++; if (busy4 !== 1'b1) $display("FAIL sole_busy got %b exp 1", busy4); else passed++;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      total++; if (grant4 !== 4'b0001 || pre4 !== 1'b0) $display("FAIL sole_hold cyc %0d got %b pre %b exp 0001 pre 0", c, grant4, pre4); else passed++;
    end
    req4 = '0;
    @(negedge clk);
    total++; if (grant4 !== 4'b0000 || busy4 !== 1'b1 || pre4 !== 1'b0) $display("FAIL sole_release got %b busy %b pre %b exp 0000 1 0", grant4, busy4, pre4); else passed++;
    @(negedge clk);
    total++; if (busy4 !== 1'b0) $display("FAIL sole_idle got busy %b exp 0", busy4); else passed++;
  endtask

  task automatic test_two();
    int owners[3] = '{0, 2, 0};
    do_reset();
    req4 = 4'b0101;
    foreach (owners[o]) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        total++; if (grant4 !== 4'(1 << owners[o]) || idx4 !== 2'(owners[o]) || pre4 !== 1'b0)
          $display("FAIL two_tenure o%0d c%0d got %b idx %0d exp owner %0d", o, c, grant4, idx4, owners[o]); else passed++;
      end
      @(negedge clk);
      total++; if (grant4 !== 4'b0000 || pre4 !== 1'b1) $display("FAIL two_gap o%0d got %b pre %b exp 0000 pre 1", o, grant4, pre4); else passed++;
    end
    req4 = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_all();
    int owners[5] = '{0, 1, 2, 3, 0};
    do_reset();
    req4 = 4'b1111;
    foreach (owners[o]) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        total++; if (grant4 !== 4'(1 << owners[o]) || !$onehot0(grant4))
          $display("FAIL all_tenure o%0d c%0d got %b exp owner %0d", o, c, grant4, owners[o]); else passed++;
      end
      @(negedge clk);
      total++; if (grant4 !== 4'b0000 || pre4 !== 1'b1) $display("FAIL all_gap o%0d got %b pre %b exp 0000 pre 1", o, grant4, pre4); else passed++;
    end
    req4 = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_lock();
    do_reset();
    req4 = 4'b0100;
    @(negedge clk);
    total++; if (grant4 !== 4'b0100) $display("FAIL lock_setup got %b exp 0100", grant4); else passed++;
    lock4 = 4'b0100;
    req4  = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      total++; if (grant4 !== 4'b0100 || pre4 !== 1'b0) $display("FAIL lock_hold c%0d got %b pre %b exp 0100 pre 0", c, grant4, pre4); else passed++;
    end
    lock4 = '0;
    @(negedge clk);
    total++; if (grant4 !== 4'b0000 || pre4 !== 1'b1) $display("FAIL lock_release got %b pre %b exp 0000 pre 1", grant4, pre4); else passed++;
    @(negedge clk);
    total++; if (grant4 !== 4'b1000 || idx4 !== 2'd3) $display("FAIL lock_next got %b idx %0d exp 1000 idx 3", grant4, idx4); else passed++;
    req4 = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_wrap3();
    do_reset();
    req3 = 3'b100;
    @(negedge clk);
    total++; if (grant3 !== 3'b100 || idx3 !== 2'd2) $display("FAIL wrap_setup got %b idx %0d exp 100 idx 2", grant3, idx3); else passed++;
    req3 = 3'b001;
    @(negedge clk);
    total++; if (grant3 !== 3'b000 || busy3 !== 1'b1 || pre3 !== 1'b0) $display("FAIL wrap_turn got %b busy %b pre %b exp 000 1 0", grant3, busy3, pre3); else passed++;
    @(negedge clk);
    total++; if (grant3 !== 3'b001 || idx3 !== 2'd0) $display("FAIL wrap_next got %b idx %0d exp 001 idx 0", grant3, idx3); else passed++;
    req3 = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_async_reset();
    do_reset();
    req4 = 4'b0001;
    @(negedge clk);
    total++; if (grant4 !== 4'b0001) $display("FAIL areset_setup got %b exp 0001", grant4); else passed++;
    #2 reset = 1'b0;
    #1;
    total++; if (grant4 !== 4'b0000 || busy4 !== 1'b0) $display("FAIL areset_drop got %b busy %b exp 0000 0", grant4, busy4); else passed++;
    @(negedge clk);
    reset = 1'b1;
    req4  = 4'b0010;
    @(negedge clk);
    total++; if (grant4 !== 4'b0010 || idx4 !== 2'd1) $display("FAIL areset_regrant got %b idx %0d exp 0010 idx 1", grant4, idx4); else passed++;
    req4 = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    logic [3:0] pg4, pr4;
    logic [2:0] pg3, pr3;
    do_reset();
    pg4 = '0; pr4 = '0; pg3 = '0; pr3 = '0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      total++; if (grant4 !== 4'(exp_grant(m4)) || idx4 !== 2'(exp_idx(m4)))
        $display("FAIL rand4_grant c%0d got %b idx %0d exp %b idx %0d", c, grant4, idx4, 4'(exp_grant(m4)), exp_idx(m4)); else passed++;
      total++; if (busy4 !== (m4.owner >= 0 || m4.gap) || pre4 !== m4.pre)
        $display("FAIL rand4_flags c%0d got busy %b pre %b exp %b %b", c, busy4, pre4, (m4.owner >= 0 || m4.gap), m4.pre); else passed++;
      total++; if (grant3 !== 3'(exp_grant(m3)) || idx3 !== 2'(exp_idx(m3)) || pre3 !== m3.pre)
        $display("FAIL rand3 c%0d got %b idx %0d pre %b exp %b idx %0d pre %b", c, grant3, idx3, pre3, 3'(exp_grant(m3)), exp_idx(m3), m3.pre); else passed++;
      total++; if (!$onehot0(grant4) || (pg4 != 0 && grant4 != 0 && grant4 !== pg4) || (grant4 & ~pg4 & ~pr4) != 0)
        $display("FAIL rand4_invariant c%0d got %b prev %b prevreq %b", c, grant4, pg4, pr4); else passed++;
      total++; if (!$onehot0(grant3) || idx3 > 2'd2 || (pg3 != 0 && grant3 != 0 && grant3 !== pg3) || (grant3 & ~pg3 & ~pr3) != 0)
        $display("FAIL rand3_invariant c%0d got %b idx %0d prev %b prevreq %b", c, grant3, idx3, pg3, pr3); else passed++;
      pg4 = grant4; pg3 = grant3;
      if ($urandom_range(3) == 0) req4 = 4'($urandom_range(15));
      if ($urandom_range(3) == 0) req3 = 3'($urandom_range(7));
      if ($urandom_range(9) == 0) lock4 = 4'($urandom_range(15));
      if ($urandom_range(9) == 0) lock3 = 3'($urandom_range(7));
      pr4 = req4; pr3 = req3;
    end
  endtask

  initial begin
    test_reset();
    test_sole();
    test_two();
    test_all();
    test_lock();
    test_wrap3();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
